// File: rtl/counter_sched_pkg.sv
// Shared types and default sizing for the counter_sched round-robin counter scheduler.
package counter_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LAUNCH    = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_RUN       = 3'd3,
    S_DONE      = 3'd4
  } sched_state_t;

  localparam int SCHED_NUM_REQ  = 4;
  localparam int SCHED_WD_START = 8;
  localparam int SCHED_WD_RUN   = 64;

endpackage

// File: rtl/counter_sched_rr_arbiter.sv
// Round-robin arbiter: searches from last_grant+1 upward, wrapping modulo NUM_REQ.
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_grant,
  input  logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx
);

  int         cand;
  logic [IDX_W-1:0] cand_idx;
  logic       found;

  // NOTE: every variable gets a default before the search so no latch is inferred.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    cand_idx  = '0;
    if (enable) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand = int'(last_grant) + 1 + i;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        cand_idx = IDX_W'(cand);
        if (!found && req[cand_idx]) begin
          found           = 1'b1;
          grant[cand_idx] = 1'b1;
          grant_idx       = cand_idx;
        end
      end
    end
  end

endmodule

// File: rtl/counter_sched.sv
// Shares one wait/check counter among NUM_REQ requesters with start/run watchdogs.
// Optional SCHED_SKIP_ZERO_EN: a zero wait value completes without starting the counter.
module counter_sched
  import counter_sched_pkg::*;
#(
  parameter int NUM_REQ  = SCHED_NUM_REQ,
  parameter int TIMER_W  = 5,
  parameter int COUNT_W  = 5,
  parameter int WD_START = SCHED_WD_START,
  parameter int WD_RUN   = SCHED_WD_RUN
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*TIMER_W-1:0]   req_wait,
  output logic [NUM_REQ-1:0]           rsp_valid,
  output logic [COUNT_W-1:0]           rsp_count,
  output logic                         rsp_err,
  output logic                         cnt_start,
  output logic [TIMER_W-1:0]           cnt_wait_timer,
  input  logic                         cnt_busy,
  input  logic [COUNT_W-1:0]           cnt_count,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         sched_busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(WD_RUN + 1);

  sched_state_t       state_q, state_d;
  logic [TIMER_W-1:0] wait_q, wait_d;
  logic [IDX_W-1:0]   grant_q, grant_d;
  logic [IDX_W-1:0]   last_grant_q, last_grant_d;
  logic [WD_W-1:0]    wd_q, wd_d, wd_inc;
  logic [COUNT_W-1:0] count_q, count_d;
  logic               err_q, err_d;

  logic               arb_en;
  logic [NUM_REQ-1:0] arb_grant;
  logic [IDX_W-1:0]   arb_idx;
  logic [TIMER_W-1:0] sel_wait;

  assign arb_en = (state_q == S_IDLE);

  rr_arbiter #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_arb (
    .req        (req_valid),
    .last_grant (last_grant_q),
    .enable     (arb_en),
    .grant      (arb_grant),
    .grant_idx  (arb_idx)
  );

  always_comb begin
    sel_wait = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (arb_grant[i]) sel_wait = req_wait[i*TIMER_W +: TIMER_W];
    end
  end

  // Saturating increment keeps the watchdog from wrapping past its limit.
  assign wd_inc = (wd_q == WD_W'(WD_RUN)) ? wd_q : wd_q + WD_W'(1);

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wd_d         = wd_q;
    count_d      = count_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          wait_d  = sel_wait;
          grant_d = arb_idx;
          state_d = S_LAUNCH;
`ifdef SCHED_SKIP_ZERO_EN
          if (sel_wait == '0) begin
            count_d = '0;
            err_d   = 1'b0;
            state_d = S_DONE;
          end
`endif
        end
      end
      S_LAUNCH: begin
        wd_d    = '0;
        state_d = S_WAIT_BUSY;
      end
      S_WAIT_BUSY: begin
        if (cnt_busy) begin
          wd_d    = '0;
          state_d = S_RUN;
        end else if (wd_inc == WD_W'(WD_START)) begin
          err_d   = 1'b1;
          count_d = '0;
          state_d = S_DONE;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_RUN: begin
        if (!cnt_busy) begin
          count_d = cnt_count;
          state_d = S_DONE;
        end else if (wd_inc == WD_W'(WD_RUN)) begin
          err_d   = 1'b1;
          count_d = '0;
          state_d = S_DONE;
        end else begin
          wd_d = wd_inc;
        end
      end
      S_DONE: begin
        last_grant_d = grant_q;
        err_d        = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments only; all next-state math stays in always_comb.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      wait_q       <= '0;
      grant_q      <= '0;
      last_grant_q <= IDX_W'(NUM_REQ - 1);
      wd_q         <= '0;
      count_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wd_q         <= wd_d;
      count_q      <= count_d;
      err_q        <= err_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state_q == S_DONE) rsp_valid[grant_q] = 1'b1;
  end

  assign req_ready      = arb_grant;
  assign rsp_count      = (state_q == S_DONE) ? count_q : '0;
  assign rsp_err        = (state_q == S_DONE) & err_q;
  assign cnt_start      = (state_q == S_LAUNCH);
  assign cnt_wait_timer = wait_q;
  assign grant_id       = grant_q;
  assign sched_busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Scoreboard bench for counter_sched with a behavioural counter model.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int TW   = 5;
  localparam int CW   = 5;
`ifdef SCHED_SKIP_ZERO_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*TW-1:0] req_wait;
  logic [NREQ-1:0]    rsp_valid;
  logic [CW-1:0]      rsp_count;
  logic               rsp_err;
  logic               cnt_start;
  logic [TW-1:0]      cnt_wait_timer;
  logic               cnt_busy;
  logic [CW-1:0]      cnt_count;
  logic [1:0]         grant_id;
  logic               sched_busy;

  counter_sched dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_wait       (req_wait),
    .rsp_valid      (rsp_valid),
    .rsp_count      (rsp_count),
    .rsp_err        (rsp_err),
    .cnt_start      (cnt_start),
    .cnt_wait_timer (cnt_wait_timer),
    .cnt_busy       (cnt_busy),
    .cnt_count      (cnt_count),
    .grant_id       (grant_id),
    .sched_busy     (sched_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NREQ-1:0] vld;
    int              idx;
    logic [CW-1:0]   cnt;
    logic            err;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Counter model: mode 0 = busy 1 cycle after start for hold_cycles, 1 = never busy, 2 = stuck busy.
  int            model_mode  = 0;
  int            hold_cycles = 4;
  int            busy_left   = 0;
  logic [CW-1:0] model_count = '0;

  assign cnt_count = model_count;

  always @(posedge clk) begin
    if (rst) begin
      cnt_busy  <= 1'b0;
      busy_left <= 0;
    end else if (cnt_start) begin
      cnt_busy  <= (model_mode != 1);
      busy_left <= hold_cycles;
    end else if (model_mode == 2) begin
      cnt_busy <= 1'b1;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      cnt_busy  <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (!rst && rsp_valid != '0) begin
      if (exp_q.size() == 0) begin
        check("rsp_unexpected", 32'(rsp_valid), 32'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
        check("rsp_grant_id", 32'(grant_id), 32'(mon_e.idx));
        check("rsp_count", 32'(rsp_count), 32'(mon_e.cnt));
        check("rsp_err", 32'(rsp_err), 32'(mon_e.err));
      end
    end
  end

  // One request from requester idx; elat = negedges from the cycle after handshake to rsp_valid.
  task automatic do_req(input int idx, input logic [TW-1:0] w, input logic [CW-1:0] ecnt,
                        input logic eerr, input int elat, input string name);
    int   cyc;
    exp_t e;
    bit   exp_start;
    exp_start = !(SKIP_EN && (w == '0));
    @(negedge clk);
    req_wait[idx*TW +: TW] = w;
    req_valid[idx] = 1'b1;
    #1;
    cyc = 0;
    while (req_ready[idx] !== 1'b1 && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    check({name, "_ready"}, 32'(req_ready), 32'(1 << idx));
    e.vld = NREQ'(1 << idx); e.idx = idx; e.cnt = ecnt; e.err = eerr;
    exp_q.push_back(e);
    @(negedge clk);
    req_valid[idx] = 1'b0;
    #1;
    check({name, "_start"}, 32'(cnt_start), 32'(exp_start));
    if (exp_start) check({name, "_wait_timer"}, 32'(cnt_wait_timer), 32'(w));
    cyc = 0;
    while (rsp_valid == '0 && cyc < 300) begin
      @(negedge clk); #1; cyc++;
      if (cyc == 1 && exp_start) check({name, "_start_pulse"}, 32'(cnt_start), 32'd0);
    end
    check({name, "_latency"}, 32'(cyc), 32'(elat));
    if (exp_start) check({name, "_wait_held"}, 32'(cnt_wait_timer), 32'(w));
  endtask

  // Holds mask valid and expects grants in the order given by seq.
  task automatic grant_seq(input logic [NREQ-1:0] mask, input int n, input int seq[5],
                           input string name);
    int   cyc;
    exp_t e;
    @(negedge clk);
    req_wait  = {5'd13, 5'd12, 5'd11, 5'd10};
    req_valid = mask;
    for (int k = 0; k < n; k++) begin
      #1;
      cyc = 0;
      while (req_ready == '0 && cyc < 200) begin
        @(negedge clk); #1; cyc++;
      end
      check({name, "_ready"}, 32'(req_ready), 32'(1 << seq[k]));
      e.vld = NREQ'(1 << seq[k]); e.idx = seq[k]; e.cnt = model_count; e.err = 1'b0;
      exp_q.push_back(e);
      @(negedge clk);
      if (k == n - 1) req_valid = '0;
      #1;
      check({name, "_grant_id"}, 32'(grant_id), 32'(seq[k]));
      check({name, "_wait_timer"}, 32'(cnt_wait_timer), 32'(10 + seq[k]));
      cyc = 0;
      while (sched_busy && cyc < 300) begin
        @(negedge clk); #1; cyc++;
      end
      check({name, "_done"}, 32'(sched_busy), 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int cyc;
    rst       = 1'b1;
    req_valid = '0;
    req_wait  = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_outputs", 32'({req_ready, rsp_valid, rsp_count, rsp_err, cnt_start,
                                cnt_wait_timer, grant_id, sched_busy}), 32'd0);

    // All requesters valid: round-robin from requester 0.
    model_mode = 0; model_count = 5'd9;
    grant_seq(4'b1111, 5, '{0, 1, 2, 3, 0}, "rr_all");

    model_count = 5'd3;
    do_req(0, 5'd3, 5'd3, 1'b0, 6, "basic");

    // Busy never rises: start watchdog fires after 8 waiting cycles.
    model_mode = 1;
    do_req(2, 5'd6, 5'd0, 1'b1, 9, "no_busy");

    // Busy stuck: run watchdog fires after 64 cycles; a dropped request in the middle is ignored.
    model_mode = 2;
    fork
      do_req(3, 5'd4, 5'd0, 1'b1, 66, "stuck");
      begin
        repeat (20) @(negedge clk);
        req_valid[1] = 1'b1;
        repeat (3) @(negedge clk);
        req_valid[1] = 1'b0;
      end
    join
    model_mode = 0;
    repeat (8) @(negedge clk);
    model_count = 5'd7;
    do_req(1, 5'd5, 5'd7, 1'b0, 6, "after_stuck");

    // Reset in S_RUN abandons the transaction, then priority restarts at requester 0.
    model_count = 5'd21;
    @(negedge clk);
    req_wait  = {5'd13, 5'd12, 5'd11, 5'd10};
    req_valid = 4'b0100;
    #1;
    cyc = 0;
    while (req_ready == '0 && cyc < 200) begin
      @(negedge clk); #1; cyc++;
    end
    check("rst_ready", 32'(req_ready), 32'b0100);
    repeat (3) @(negedge clk);
    check("rst_in_run", 32'({sched_busy, cnt_busy}), 32'b11);
    rst       = 1'b1;
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_outputs", 32'({req_ready, rsp_valid, rsp_count, rsp_err, cnt_start,
                              cnt_wait_timer, grant_id, sched_busy}), 32'd0);
    grant_seq(4'b0101, 2, '{0, 2, 0, 0, 0}, "rst_rr");

    // Wait value zero.
    model_count = 5'd17;
    if (SKIP_EN) do_req(1, 5'd0, 5'd0, 1'b0, 0, "zero_wait");
    else         do_req(1, 5'd0, 5'd17, 1'b0, 6, "zero_wait");

    repeat (10) @(negedge clk);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/counter_sched.md
Name: counter_sched

Overview:
- Round-robin scheduler that shares one wait/check counter (start, wait_timer, busy, count interface) among NUM_REQ requesters.
- Accepts one request at a time and issues a one-cycle start pulse with the requester's wait value.
- Tracks the counter's busy window with watchdogs, then returns the sampled count, or an error, to the granted requester.
- Sits between the requester blocks and the single counter instance.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
TIMER_W, 5, width of wait_timer value
COUNT_W, 5, width of counter result
WD_START, 8, max cycles after start for busy to rise
WD_RUN, 64, max cycles busy may stay high

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-requester request
req_ready  out  NUM_REQ  per-requester accept; at most one bit set
req_wait  in  NUM_REQ*TIMER_W  flat wait values; requester i uses slice [i*TIMER_W +: TIMER_W]
rsp_valid  out  NUM_REQ  one-hot, one-cycle completion pulse
rsp_count  out  COUNT_W  result; valid with rsp_valid
rsp_err  out  1  watchdog error; valid with rsp_valid
cnt_start  out  1  one-cycle start pulse to counter
cnt_wait_timer  out  TIMER_W  wait value to counter
cnt_busy  in  1  counter busy
cnt_count  in  COUNT_W  counter result
grant_id  out  $clog2(NUM_REQ)  index of current or last grant
sched_busy  out  1  high in every state except S_IDLE

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous, active-high.
- Reset values: all outputs 0; state S_IDLE; last_grant = NUM_REQ-1, so requester 0 has first priority.
- Reset mid-operation: the transaction is abandoned, no rsp_valid is issued, and cnt_start is 0 in the next cycle.
- States: S_IDLE, S_LAUNCH, S_WAIT_BUSY, S_RUN, S_DONE.
- S_IDLE:
  - Round-robin search begins at last_grant+1 and wraps modulo NUM_REQ.
  - req_ready[g] = 1 combinationally, for the selected g only, when req_valid[g] = 1.
  - On handshake: latch req_wait slice g into wait_q, set grant_id = g, go to S_LAUNCH.
  - No valid request: stay in S_IDLE; req_ready = 0.
- S_LAUNCH:
  - cnt_start = 1 for exactly this cycle.
  - cnt_wait_timer = wait_q, held stable until S_DONE exits.
  - Clear the watchdog counter; go to S_WAIT_BUSY.
- S_WAIT_BUSY:
  - cnt_busy = 1: go to S_RUN and clear the watchdog.
  - Watchdog reaches WD_START without cnt_busy: set err_q, count_q = 0, go to S_DONE.
- S_RUN:
  - cnt_busy = 0: capture cnt_count into count_q in that same cycle, go to S_DONE.
  - Watchdog reaches WD_RUN: set err_q, count_q = 0, go to S_DONE.
- S_DONE:
  - rsp_valid[grant_id] = 1, rsp_count = count_q, rsp_err = err_q, all for one cycle.
  - last_grant = grant_id; clear err_q; go to S_IDLE.
- Latency: handshake at cycle T, cnt_start at T+1. rsp_valid arrives 1 cycle after the cycle in which busy is seen low.
- Throughput: minimum 5 cycles per transaction. Accept and response never occur in the same cycle.
- Watchdog width: $clog2(WD_RUN+1). It does not wrap; it saturates at its limit.
- Dropped request: if req_valid drops before handshake, nothing is latched.
- Wait value 0: forwarded to the counter unchanged (without the optional feature).

Optional Feature:
- Macro: SCHED_SKIP_ZERO_EN.
- Defined: a handshake with wait value 0 goes directly from S_IDLE to S_DONE. No cnt_start is issued; rsp_count = 0, rsp_err = 0; latency is 1 cycle.
- Undefined: wait value 0 follows the normal path.

Decomposition:
- Package counter_sched_pkg holds:
  - typedef enum logic [2:0] sched_state_t.
  - Default constants SCHED_NUM_REQ, SCHED_WD_START, SCHED_WD_RUN.
- Sub-module rr_arbiter:
  - Parameterised on NUM_REQ.
  - Inputs: req vector, last_grant, enable.
  - Outputs: one-hot grant and encoded index.

Test Plan:
- Req0 wait=3; counter model raises busy 1 cycle after start, holds it 4 cycles, count=3 -> cnt_start at T+1, cnt_wait_timer=3, rsp_valid=4'b0001, rsp_count=3, rsp_err=0.
- All four req_valid held high -> grants 0,1,2,3, then 0 again; each rsp_valid is one-hot and matches grant_id.
- Counter never raises busy -> rsp_err=1, rsp_count=0, rsp_valid asserted 8 cycles after cnt_start plus DONE.
- Busy stuck high -> rsp_err=1 after 64 RUN cycles; next request is granted normally.
- rst pulsed in S_RUN with req2 active -> all outputs 0 the next cycle, no rsp. With req0 and req2 then both valid, req0 is granted first.
- Req1 wait=0 -> without SCHED_SKIP_ZERO_EN: cnt_start=1, cnt_wait_timer=0. With it: no cnt_start, rsp_valid[1] 1 cycle after handshake, count 0.
